// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, op width, FSM states
// and small op-classification helpers used by both the MDU and the ID-stage decoder.
package mdu_pkg;

    localparam int MDU_OP_W = 4;

    localparam logic [MDU_OP_W-1:0] MDU_NOP   = 4'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd5;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd6;
    localparam logic [MDU_OP_W-1:0] MDU_MADD  = 4'd7;
    localparam logic [MDU_OP_W-1:0] MDU_MADDU = 4'd8;
    localparam logic [MDU_OP_W-1:0] MDU_MSUB  = 4'd9;
    localparam logic [MDU_OP_W-1:0] MDU_MSUBU = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Ops that occupy the unit for several cycles and commit through the pending registers.
    function automatic logic is_multi_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU) ||
               (op == MDU_MADD) || (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result datapath of the MDU: computes the next HI/LO pair for any op
// from the operands and the current HI/LO, and flags division by zero.
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [MDU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic [WIDTH-1:0]    hi,
    input  logic [WIDTH-1:0]    lo,
    output logic [WIDTH-1:0]    next_hi,
    output logic [WIDTH-1:0]    next_lo,
    output logic                div_zero
);

    logic [2*WIDTH-1:0] a_s, b_s, a_u, b_u;
    logic [2*WIDTH-1:0] prod_s, prod_u, acc, res;
    logic [WIDTH-1:0]   divisor, abs_a, abs_b, q_mag, r_mag;
    logic [WIDTH-1:0]   q_s, r_s, q_u, r_u;

    always_comb begin
        a_s    = {{WIDTH{in_a[WIDTH-1]}}, in_a};
        b_s    = {{WIDTH{in_b[WIDTH-1]}}, in_b};
        a_u    = {{WIDTH{1'b0}}, in_a};
        b_u    = {{WIDTH{1'b0}}, in_b};
        // Low 2*WIDTH bits of the sign-extended product equal the signed product.
        prod_s = a_s * b_s;
        prod_u = a_u * b_u;
        acc    = {hi, lo};

        div_zero = is_div_op(op) && (in_b == '0);
        // A zero divisor is replaced by 1 so the dividers never see /0; the result is discarded.
        divisor  = (in_b == '0) ? WIDTH'(1) : in_b;

        abs_a = in_a[WIDTH-1] ? -in_a : in_a;
        abs_b = divisor[WIDTH-1] ? -divisor : divisor;
        q_mag = abs_a / abs_b;
        r_mag = abs_a % abs_b;
        // Most-negative / -1 falls out as quotient = most-negative, remainder = 0.
        q_s   = (in_a[WIDTH-1] ^ divisor[WIDTH-1]) ? -q_mag : q_mag;
        r_s   = in_a[WIDTH-1] ? -r_mag : r_mag;
        q_u   = in_a / divisor;
        r_u   = in_a % divisor;

        res = acc;
        case (op)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV:   res = div_zero ? acc : {r_s, q_s};
            MDU_DIVU:  res = div_zero ? acc : {r_u, q_u};
            MDU_MTHI:  res = {in_a, lo};
            MDU_MTLO:  res = {hi, in_a};
            MDU_MADD:  res = acc + prod_s;
            MDU_MADDU: res = acc + prod_u;
            MDU_MSUB:  res = acc - prod_s;
            MDU_MSUBU: res = acc - prod_u;
            default:   res = acc;
        endcase

        next_hi = res[2*WIDTH-1:WIDTH];
        next_lo = res[WIDTH-1:0];
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers. Results are computed at accept,
// held in pending registers, and committed to HI/LO when the busy countdown expires.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    inA,
    input  logic [WIDTH-1:0]    inB,
    output logic                busy,
    output logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] calc_hi, calc_lo;
    logic             div_zero;
    logic             accept;

    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .op       (op),
        .in_a     (inA),
        .in_b     (inB),
        .hi       (hi_q),
        .lo       (lo_q),
        .next_hi  (calc_hi),
        .next_lo  (calc_lo),
        .div_zero (div_zero)
    );

    // A start while busy is dropped entirely, including MTHI/MTLO.
    assign accept = start && !busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && is_multi_op(op)) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_ONE) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        p_hi_d = p_hi_q;
        p_lo_d = p_lo_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        busy_d = (state_d == ST_RUN);
        if (state_q == ST_IDLE) begin
            if (accept && is_multi_op(op)) begin
                cnt_d  = is_div_op(op) ? DIV_N : MULT_N;
                p_hi_d = div_zero ? hi_q : calc_hi;
                p_lo_d = div_zero ? lo_q : calc_lo;
            end else if (accept && (op == MDU_MTHI)) begin
                hi_d = inA;
            end else if (accept && (op == MDU_MTLO)) begin
                lo_d = inA;
            end
        end else begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                hi_d = p_hi_q;
                lo_d = p_lo_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            p_hi_q <= '0;
            p_lo_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            p_hi_q <= p_hi_d;
            p_lo_q <= p_lo_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu with WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .inA   (in_a),
        .inB   (in_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one op for one edge, then measures how many sampled cycles busy stays high
    // and whether hi/lo moved during that time. Returns #1 after the edge busy fell.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output bit moved);
        logic [31:0] hi0, lo0;
        @(negedge clk);
        start = 1'b1; op = o; in_a = a; in_b = b;
        hi0 = hi; lo0 = lo;
        @(posedge clk); #1;
        start = 1'b0; op = MDU_NOP;
        cycles = 0; moved = 1'b0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            if (hi !== hi0 || lo !== lo0) moved = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = MDU_NOP; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mult();
        int cyc; bit mv;
        run_op(MDU_MULT, 32'hFFFFFFFE, 32'd3, cyc, mv);
        checks++; if (cyc != 5) begin failures++; $display("FAIL mult_busy: got %0d cycles expected 5", cyc); end
        checks++; if (mv) begin failures++; $display("FAIL mult_stable: got hi/lo moved while busy expected stable"); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi: got %h expected FFFFFFFF", hi); end
        checks++; if (lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo: got %h expected FFFFFFFA", lo); end
        run_op(MDU_MULTU, 32'hFFFFFFFE, 32'd3, cyc, mv);
        checks++; if (cyc != 5) begin failures++; $display("FAIL multu_busy: got %0d cycles expected 5", cyc); end
        checks++; if (hi !== 32'h00000002) begin failures++; $display("FAIL multu_hi: got %h expected 00000002", hi); end
        checks++; if (lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL multu_lo: got %h expected FFFFFFFA", lo); end
    endtask

    task automatic test_div();
        int cyc; bit mv;
        run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, cyc, mv);
        checks++; if (cyc != 10) begin failures++; $display("FAIL div_busy: got %0d cycles expected 10", cyc); end
        checks++; if (mv) begin failures++; $display("FAIL div_stable: got hi/lo moved while busy expected stable"); end
        checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo: got %h expected FFFFFFFD", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi: got %h expected FFFFFFFF", hi); end
        run_op(MDU_DIVU, 32'd7, 32'd2, cyc, mv);
        checks++; if (lo !== 32'd3) begin failures++; $display("FAIL divu_lo: got %h expected 00000003", lo); end
        checks++; if (hi !== 32'd1) begin failures++; $display("FAIL divu_hi: got %h expected 00000001", hi); end
    endtask

    task automatic test_mac();
        int cyc; bit mv;
        run_op(MDU_MTHI, 32'h0, 32'h0, cyc, mv);
        run_op(MDU_MTLO, 32'd5, 32'h0, cyc, mv);
        checks++; if (cyc != 0) begin failures++; $display("FAIL mtlo_busy: got %0d cycles expected 0", cyc); end
        checks++; if (lo !== 32'd5) begin failures++; $display("FAIL mtlo_lo: got %h expected 00000005", lo); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL mthi_hi: got %h expected 00000000", hi); end
        run_op(MDU_MSUB, 32'd2, 32'd3, cyc, mv);
        checks++; if (cyc != 5) begin failures++; $display("FAIL msub_busy: got %0d cycles expected 5", cyc); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL msub_hi: got %h expected FFFFFFFF", hi); end
        checks++; if (lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL msub_lo: got %h expected FFFFFFFF", lo); end
        run_op(MDU_MTHI, 32'h0, 32'h0, cyc, mv);
        run_op(MDU_MTLO, 32'hFFFFFFFF, 32'h0, cyc, mv);
        run_op(MDU_MADDU, 32'd1, 32'd1, cyc, mv);
        checks++; if (hi !== 32'd1) begin failures++; $display("FAIL maddu_hi: got %h expected 00000001", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL maddu_lo: got %h expected 00000000", lo); end
    endtask

    task automatic test_edge_div();
        int cyc; bit mv;
        run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, cyc, mv);
        checks++; if (lo !== 32'h80000000) begin failures++; $display("FAIL divovf_lo: got %h expected 80000000", lo); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL divovf_hi: got %h expected 00000000", hi); end
        run_op(MDU_MTHI, 32'h11, 32'h0, cyc, mv);
        run_op(MDU_MTLO, 32'h22, 32'h0, cyc, mv);
        run_op(MDU_DIVU, 32'd9, 32'd0, cyc, mv);
        checks++; if (cyc != 10) begin failures++; $display("FAIL divzero_busy: got %0d cycles expected 10", cyc); end
        checks++; if (hi !== 32'h11) begin failures++; $display("FAIL divzero_hi: got %h expected 00000011", hi); end
        checks++; if (lo !== 32'h22) begin failures++; $display("FAIL divzero_lo: got %h expected 00000022", lo); end
    endtask

    // Minimum issue interval: the second op is driven for the edge right after busy falls.
    task automatic test_back_to_back();
        int cyc; bit mv;
        run_op(MDU_MULTU, 32'h10, 32'h10, cyc, mv);
        checks++; if (lo !== 32'h100) begin failures++; $display("FAIL b2b_first_lo: got %h expected 00000100", lo); end
        run_op(MDU_DIVU, 32'd100, 32'd7, cyc, mv);
        checks++; if (cyc != 10) begin failures++; $display("FAIL b2b_second_busy: got %0d cycles expected 10", cyc); end
        checks++; if (lo !== 32'd14) begin failures++; $display("FAIL b2b_second_lo: got %h expected 0000000E", lo); end
        checks++; if (hi !== 32'd2) begin failures++; $display("FAIL b2b_second_hi: got %h expected 00000002", hi); end
    endtask

    task automatic test_start_during_busy();
        logic [31:0] lo0;
        lo0 = lo;
        @(negedge clk);
        start = 1'b1; op = MDU_MULT; in_a = 32'd2; in_b = 32'd2;
        @(posedge clk); #1;           // accept edge t
        start = 1'b0; op = MDU_NOP;
        @(posedge clk);               // edge t+1
        @(negedge clk);
        start = 1'b1; op = MDU_MTLO; in_a = 32'h55;
        @(posedge clk);               // edge t+2
        @(negedge clk);
        op = MDU_DIV; in_a = 32'd8; in_b = 32'd2;
        @(posedge clk); #1;           // edge t+3
        start = 1'b0; op = MDU_NOP;
        checks++; if (lo !== lo0) begin failures++; $display("FAIL busy_mtlo_ignored: got %h expected %h", lo, lo0); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_t3: got %b expected 1", busy); end
        @(posedge clk); #1;           // edge t+4
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_t4: got %b expected 1", busy); end
        @(posedge clk); #1;           // edge t+5
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_t5: got %b expected 0", busy); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL busy_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'd4) begin failures++; $display("FAIL busy_lo: got %h expected 00000004", lo); end
        repeat (12) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_div_ignored: got %b expected 0", busy); end
        checks++; if (lo !== 32'd4) begin failures++; $display("FAIL busy_lo_late: got %h expected 00000004", lo); end
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        start = 1'b1; op = MDU_MULT; in_a = 32'd6; in_b = 32'd7;
        @(posedge clk); #1;           // accept edge t
        start = 1'b0; op = MDU_NOP;
        @(posedge clk);               // edge t+1
        @(posedge clk);               // edge t+2
        @(negedge clk);
        reset = 1'b1;                 // busy cycle 3
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstbusy_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL rstbusy_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL rstbusy_lo: got %h expected 00000000", lo); end
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstbusy_late_busy: got %b expected 0", busy); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL rstbusy_no_commit_lo: got %h expected 00000000", lo); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL rstbusy_no_commit_hi: got %h expected 00000000", hi); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_mult();
        test_div();
        test_mac();
        test_edge_div();
        test_back_to_back();
        test_start_during_busy();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
